systolic_row_collector: RTL



---
 rtl/systolic_pkg.sv | 15 +
 rtl/lane_deskew.sv | 34 +++
 rtl/systolic_row_collector.sv | 138 +++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and lane packing helper for the systolic prep/collect blocks
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Lane 0 occupies the most significant element of a packed vector.
  function automatic int lane_lsb(input int lane, input int lanes, input int width);
    return width * (lanes - 1 - lane);
  endfunction

endpackage

// File: rtl/lane_deskew.sv
// rtl/lane_deskew.sv - fixed-depth register delay line for one systolic lane (depth 0 is a wire)
module lane_deskew #(
  parameter int data_size = 16,
  parameter int depth     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic [data_size-1:0] i_data,
  output logic [data_size-1:0] o_data
);

  generate
    if (depth == 0) begin : g_wire
      logic w_unused_ok;
      assign w_unused_ok = clk ^ reset ^ i_clear;
      assign o_data      = i_data;
    end else begin : g_pipe
      logic [data_size-1:0] r_pipe [depth];

      always_ff @(posedge clk) begin
        if (reset || i_clear) begin
          for (int k = 0; k < depth; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= i_data;
          for (int k = 1; k < depth; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end

      assign o_data = r_pipe[depth-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_row_collector.sv
// rtl/systolic_row_collector.sv - de-skews systolic result lanes, buffers one matrix, replays it row by row
module systolic_row_collector
  import systolic_pkg::*;
#(
  parameter int data_size = 16,
  parameter int size      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [data_size*size-1:0] skewed_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      start_new_layer,
  output logic [data_size*size-1:0] row_out,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      layer_done,
  output logic                      overflow
);

  localparam int CNT_W = $clog2(size + 1);
  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_row_cnt, w_row_cnt_nxt;
  logic [CNT_W-1:0]          r_drain_cnt, w_drain_cnt_nxt;
  logic [data_size*size-1:0] r_buffer [size];
  logic                      r_layer_done;
  logic                      r_overflow;

  logic [data_size*size-1:0] w_aligned_row;
  logic                      w_aligned_valid;
  logic                      w_pipe_in_valid;
  logic                      w_in_ready;
  logic                      w_capture;
  logic                      w_last_accept;

  assign w_in_ready      = (r_state != DRAIN);
  // Rows offered while draining never enter the valid pipe, so they cannot be captured later.
  assign w_pipe_in_valid = in_valid & w_in_ready;

  generate
    for (genvar i = 0; i < size; i++) begin : g_lane
      lane_deskew #(
        .data_size (data_size),
        .depth     (size - 1 - i)
      ) u_lane (
        .clk     (clk),
        .reset   (reset),
        .i_clear (1'b0),
        .i_data  (skewed_in[lane_lsb(i, size, data_size) +: data_size]),
        .o_data  (w_aligned_row[lane_lsb(i, size, data_size) +: data_size])
      );
    end
  endgenerate

  lane_deskew #(
    .data_size (1),
    .depth     (size - 1)
  ) u_valid (
    .clk     (clk),
    .reset   (reset),
    .i_clear (start_new_layer),
    .i_data  (w_pipe_in_valid),
    .o_data  (w_aligned_valid)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_row_cnt_nxt   = r_row_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_capture       = 1'b0;
    w_last_accept   = 1'b0;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (w_aligned_valid) begin
          w_capture     = 1'b1;
          w_row_cnt_nxt = r_row_cnt + CNT_W'(1);
          if (r_row_cnt == CNT_W'(size - 1)) begin
            w_state_nxt     = DRAIN;
            w_drain_cnt_nxt = '0;
          end else begin
            w_state_nxt = COLLECT;
          end
        end
      end
      DRAIN: begin
        if (row_ready) begin
          if (r_drain_cnt == CNT_W'(size - 1)) begin
            w_last_accept   = 1'b1;
            w_state_nxt     = IDLE;
            w_row_cnt_nxt   = '0;
            w_drain_cnt_nxt = '0;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_row_cnt_nxt = '0;
      end
    endcase
    if (start_new_layer) begin
      w_state_nxt     = IDLE;
      w_row_cnt_nxt   = '0;
      w_drain_cnt_nxt = '0;
      w_capture       = 1'b0;
      w_last_accept   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_row_cnt    <= '0;
      r_drain_cnt  <= '0;
      r_layer_done <= 1'b0;
      r_overflow   <= 1'b0;
      for (int k = 0; k < size; k++) r_buffer[k] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_row_cnt    <= w_row_cnt_nxt;
      r_drain_cnt  <= w_drain_cnt_nxt;
      r_layer_done <= w_last_accept;
      if (w_capture) r_buffer[r_row_cnt[IDX_W-1:0]] <= w_aligned_row;
      // Sticky: a refused row, or a row still in the skew pipe when draining began.
      if ((in_valid && !w_in_ready) || (r_state == DRAIN && w_aligned_valid)) r_overflow <= 1'b1;
    end
  end

  assign in_ready   = w_in_ready;
  assign row_valid  = (r_state == DRAIN);
  assign row_out    = (r_state == DRAIN) ? r_buffer[r_drain_cnt[IDX_W-1:0]] : '0;
  assign layer_done = r_layer_done;
  assign overflow   = r_overflow;

endmodule
